// File: rtl/rsp_s1_prep_ahbic_outm0.sv
// AHB bus-matrix output stage for one slave port: arbitrates three input stages,
// muxes the winning address phase onto the slave and steers HWDATA by data-phase owner.
module rsp_s1_prep_ahbic_outm0 #(
    parameter int ARB_RR = 1,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              sel_op0,
    input  logic [31:0]       addr_op0,
    input  logic [1:0]        trans_op0,
    input  logic              write_op0,
    input  logic [2:0]        size_op0,
    input  logic [2:0]        burst_op0,
    input  logic [3:0]        prot_op0,
    input  logic              mastlock_op0,
    input  logic [DATA_W-1:0] wdata_op0,
    input  logic              sel_op1,
    input  logic [31:0]       addr_op1,
    input  logic [1:0]        trans_op1,
    input  logic              write_op1,
    input  logic [2:0]        size_op1,
    input  logic [2:0]        burst_op1,
    input  logic [3:0]        prot_op1,
    input  logic              mastlock_op1,
    input  logic [DATA_W-1:0] wdata_op1,
    input  logic              sel_op2,
    input  logic [31:0]       addr_op2,
    input  logic [1:0]        trans_op2,
    input  logic              write_op2,
    input  logic [2:0]        size_op2,
    input  logic [2:0]        burst_op2,
    input  logic [3:0]        prot_op2,
    input  logic              mastlock_op2,
    input  logic [DATA_W-1:0] wdata_op2,
    output logic              active_op0,
    output logic              active_op1,
    output logic              active_op2,
    output logic              HSELM,
    output logic [31:0]       HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic [DATA_W-1:0] HWDATAM,
    output logic              HREADYMUXM,
    input  logic              HREADYOUTM
);
    localparam logic [1:0] NONE       = 2'd3;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    // Slot 3 of every array is tied to zero so "no owner" selects all-zero controls.
    logic [3:0]        sel_a;
    logic [3:0]        lock_a;
    logic [3:0]        write_a;
    logic [1:0]        trans_a [4];
    logic [31:0]       addr_a  [4];
    logic [2:0]        size_a  [4];
    logic [2:0]        burst_a [4];
    logic [3:0]        prot_a  [4];
    logic [DATA_W-1:0] wdata_a [4];
    logic [2:0]        req;

    assign sel_a   = {1'b0, sel_op2, sel_op1, sel_op0};
    assign lock_a  = {1'b0, mastlock_op2, mastlock_op1, mastlock_op0};
    assign write_a = {1'b0, write_op2, write_op1, write_op0};
    assign trans_a = '{trans_op0, trans_op1, trans_op2, 2'b00};
    assign addr_a  = '{addr_op0, addr_op1, addr_op2, 32'd0};
    assign size_a  = '{size_op0, size_op1, size_op2, 3'd0};
    assign burst_a = '{burst_op0, burst_op1, burst_op2, 3'd0};
    assign prot_a  = '{prot_op0, prot_op1, prot_op2, 4'd0};
    assign wdata_a = '{wdata_op0, wdata_op1, wdata_op2, {DATA_W{1'b0}}};

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
        assign req[gi] = sel_a[gi] & (trans_a[gi] != HTRANS_IDLE);
    end

    logic [1:0] addr_port_q, addr_port_d;
    logic [1:0] data_port_q, data_port_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic       lock_q, lock_d;
    logic [1:0] winner;
    logic [1:0] addr_port;
    logic       owner_cont;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = NONE;
        if (ARB_RR != 0) begin
            for (int k = 3; k >= 1; k--) begin
                if (req[(int'(last_grant_q) + k) % 3]) begin
                    winner = 2'((int'(last_grant_q) + k) % 3);
                end
            end
        end else begin
            for (int k = 2; k >= 0; k--) begin
                if (req[k]) begin
                    winner = 2'(k);
                end
            end
        end
    end

    assign owner_cont = lock_q | lock_a[addr_port_q]
                      | (trans_a[addr_port_q] == HTRANS_BUSY)
                      | (trans_a[addr_port_q] == HTRANS_SEQ);

    always_comb begin
        addr_port = winner;
        if (HRESET) begin
            addr_port = NONE;
        end else if (!HREADYMUXM) begin
            addr_port = addr_port_q;
        end else if ((addr_port_q != NONE) && owner_cont) begin
            addr_port = addr_port_q;
        end
    end

    always_comb begin
        addr_port_d  = addr_port;
        data_port_d  = data_port_q;
        lock_d       = lock_q;
        last_grant_d = last_grant_q;
        if (HREADYMUXM) begin
            data_port_d = addr_port;
            lock_d      = HMASTLOCKM;
            if (addr_port != NONE) begin
                last_grant_d = addr_port;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_port_q  <= NONE;
            data_port_q  <= NONE;
            lock_q       <= 1'b0;
            last_grant_q <= 2'd2;
        end else begin
            addr_port_q  <= addr_port_d;
            data_port_q  <= data_port_d;
            lock_q       <= lock_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign active_op0 = (addr_port == 2'd0);
    assign active_op1 = (addr_port == 2'd1);
    assign active_op2 = (addr_port == 2'd2);
    assign HSELM      = sel_a[addr_port];
    assign HADDRM     = addr_a[addr_port];
    assign HTRANSM    = trans_a[addr_port];
    assign HWRITEM    = write_a[addr_port];
    assign HSIZEM     = size_a[addr_port];
    assign HBURSTM    = burst_a[addr_port];
    assign HPROTM     = prot_a[addr_port];
    assign HMASTLOCKM = lock_a[addr_port];
    assign HWDATAM    = wdata_a[data_port_q];
    assign HREADYMUXM = (data_port_q == NONE) ? 1'b1 : HREADYOUTM;
endmodule
